systolic_ctrl: RTL and testbench

//  Job sequencer for the N1xN2 output-stationary systolic array. On a start handshake it

---
 rtl/systolic_ctrl_pkg.sv | 20 ++
 rtl/systolic_ctrl_if.sv | 30 +++
 rtl/systolic_ctrl_drain.sv | 57 +++++
 rtl/systolic_ctrl.sv | 164 ++++++++++++++++
 tb/tb_systolic_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_ctrl_pkg.sv
// rtl/systolic_ctrl_pkg.sv - shared state type, default geometry and step-count helper
package systolic_ctrl_pkg;

    localparam int N1_DEF = 8;
    localparam int N2_DEF = 4;
    localparam int AW_DEF = 10;
    localparam int K_W_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } ctrl_state_t;

    // Last issue step: the final flush init reaches PE(N1-1,N2-1) at K+N1+N2-2.
    function automatic int t_end_calc(input int k, input int n1, input int n2);
        return k + n1 + n2 - 2;
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// rtl/systolic_ctrl_if.sv - job handshake plus operand-memory and array-side signals
interface systolic_ctrl_if #(
    parameter int N1  = 8,
    parameter int N2  = 4,
    parameter int AW  = 10,
    parameter int K_W = 11
);
    logic                start;
    logic [K_W-1:0]      k_len;
    logic                start_ready;
    logic                busy;
    logic                done;
    logic                err;
    logic [N1-1:0]       a_rd_en;
    logic [N1*AW-1:0]    a_rd_addr;
    logic [N2-1:0]       b_rd_en;
    logic [N2*AW-1:0]    b_rd_addr;
    logic [N1*N2-1:0]    init;
    logic [N1-1:0]       valid_D;

    modport master (
        output start, k_len, valid_D,
        input  start_ready, busy, done, err, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, init
    );

    modport slave (
        input  start, k_len, valid_D,
        output start_ready, busy, done, err, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, init
    );
endinterface

// File: rtl/systolic_ctrl_drain.sv
// rtl/systolic_ctrl_drain.sv - windowed per-row result counters and drain timeout
module systolic_ctrl_drain #(
    parameter int N1       = 8,
    parameter int N2       = 4,
    parameter int STEP_W   = 12,
    parameter int RD_LAT   = 1,
    parameter int DRAIN_TO = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_drain,
    input  logic [STEP_W-1:0] i_t,
    input  logic [STEP_W-1:0] i_k,
    input  logic [N1-1:0]     i_valid,
    output logic              o_all_done,
    output logic              o_timeout
);
    localparam int CW = $clog2(N2 + 1);
    localparam int TW = $clog2(DRAIN_TO + 1);
    typedef logic [STEP_W-1:0] step_t;

    logic [CW-1:0] r_cnt [N1];
    logic [TW-1:0] r_to;

    // Pulses before K+i+RD_LAT belong to the first-wave unload and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N1; i++) r_cnt[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < N1; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N1; i++) begin
                if (i_valid[i] && (i_t >= i_k + step_t'(i + RD_LAT)) && (r_cnt[i] != CW'(N2)))
                    r_cnt[i] <= r_cnt[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_to <= '0;
        else if (i_drain)
            r_to <= r_to + TW'(1);
        else
            r_to <= '0;
    end

    always_comb begin
        o_all_done = 1'b1;
        for (int i = 0; i < N1; i++)
            if (r_cnt[i] != CW'(N2)) o_all_done = 1'b0;
    end

    assign o_timeout = i_drain && (r_to == TW'(DRAIN_TO - 1));

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - job sequencer: skewed operand reads, init/flush wavefronts, drain and done
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int N1       = N1_DEF,
    parameter int N2       = N2_DEF,
    parameter int AW       = AW_DEF,
    parameter int K_W      = K_W_DEF,
    parameter int RD_LAT   = 1,
    parameter int K_MIN    = 6,
    parameter int DRAIN_TO = 256
) (
    input  logic           clk,
    input  logic           rst,
    systolic_ctrl_if.slave bus
);
    localparam int STEP_W = K_W + 1;
    typedef logic [STEP_W-1:0] step_t;

    ctrl_state_t          r_state;
    step_t                r_t;
    logic [K_W-1:0]       r_k;
    logic                 r_start_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [N1*N2-1:0]     r_init_pipe [RD_LAT];

    step_t                w_k;
    step_t                w_t_end;
    logic                 w_k_ok;
    logic                 w_pipe_empty;
    logic                 w_all_done;
    logic                 w_timeout;
    logic                 w_idle;
    logic                 w_drain;
    logic [N1-1:0]        w_a_en;
    logic [N1*AW-1:0]     w_a_addr;
    logic [N2-1:0]        w_b_en;
    logic [N2*AW-1:0]     w_b_addr;
    logic [N1*N2-1:0]     w_init_raw;

    assign w_k     = step_t'(r_k);
    assign w_t_end = step_t'(t_end_calc(int'(r_k), N1, N2));
    assign w_k_ok  = (int'(bus.k_len) >= K_MIN) && (int'(bus.k_len) <= (1 << AW));
    assign w_idle  = (r_state == ST_IDLE);
    assign w_drain = (r_state == ST_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_t           <= '0;
            r_k           <= '0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (w_k_ok) begin
                            r_state       <= ST_ISSUE;
                            r_k           <= bus.k_len;
                            r_t           <= '0;
                            r_busy        <= 1'b1;
                            r_start_ready <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_t <= r_t + step_t'(1);
                    if (r_t == w_t_end) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // t keeps running so the counting window stays valid while draining.
                    if (r_t != '1) r_t <= r_t + step_t'(1);
                    if ((w_all_done && w_pipe_empty) || w_timeout) begin
                        r_done        <= 1'b1;
                        r_err         <= !(w_all_done && w_pipe_empty);
                        r_busy        <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_a_en     = '0;
        w_a_addr   = '0;
        w_b_en     = '0;
        w_b_addr   = '0;
        w_init_raw = '0;
        if (r_state == ST_ISSUE) begin
            for (int i = 0; i < N1; i++) begin
                if ((r_t >= step_t'(i)) && ((r_t - step_t'(i)) < w_k)) begin
                    w_a_en[i]            = 1'b1;
                    w_a_addr[i*AW +: AW] = AW'(r_t - step_t'(i));
                end
            end
            for (int j = 0; j < N2; j++) begin
                if ((r_t >= step_t'(j)) && ((r_t - step_t'(j)) < w_k)) begin
                    w_b_en[j]            = 1'b1;
                    w_b_addr[j*AW +: AW] = AW'(r_t - step_t'(j));
                end
            end
            // Second term is the zero-data flush wave that unloads the results.
            for (int i = 0; i < N1; i++)
                for (int j = 0; j < N2; j++)
                    w_init_raw[i*N2 + j] = (r_t == step_t'(i + j)) || (r_t == w_k + step_t'(i + j));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) r_init_pipe[s] <= '0;
        end else begin
            r_init_pipe[0] <= w_init_raw;
            for (int s = 1; s < RD_LAT; s++) r_init_pipe[s] <= r_init_pipe[s-1];
        end
    end

    always_comb begin
        w_pipe_empty = 1'b1;
        for (int s = 0; s < RD_LAT; s++)
            if (r_init_pipe[s] != '0) w_pipe_empty = 1'b0;
    end

    systolic_ctrl_drain #(
        .N1       (N1),
        .N2       (N2),
        .STEP_W   (STEP_W),
        .RD_LAT   (RD_LAT),
        .DRAIN_TO (DRAIN_TO)
    ) u_drain (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_idle),
        .i_drain    (w_drain),
        .i_t        (r_t),
        .i_k        (w_k),
        .i_valid    (bus.valid_D),
        .o_all_done (w_all_done),
        .o_timeout  (w_timeout)
    );

    assign bus.start_ready = r_start_ready;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.a_rd_en     = w_a_en;
    assign bus.a_rd_addr   = w_a_addr;
    assign bus.b_rd_en     = w_b_en;
    assign bus.b_rd_addr   = w_b_addr;
    assign bus.init        = r_init_pipe[RD_LAT-1];

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - scoreboard bench for systolic_ctrl with a small array pulse model
module tb_systolic_ctrl;
    localparam int N1 = 8;
    localparam int N2 = 4;
    localparam int AW = 10;
    localparam int K_W = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_ctrl_if #(.N1(N1), .N2(N2), .AW(AW), .K_W(K_W)) bus ();

    systolic_ctrl #(
        .N1(N1), .N2(N2), .AW(AW), .K_W(K_W),
        .RD_LAT(1), .K_MIN(6), .DRAIN_TO(256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {int done; int err; int sready; int t_lo; int t_hi; int ones;} ev_t;
    typedef struct {int sig; int t; int v;} edge_t;

    ev_t   q_ev[$];
    edge_t q_edge[$];
    int    q_addr7[$];
    bit    chk_waves = 1'b0;
    int    jobs = 0;
    int    checks = 0;
    int    failures = 0;

    int drv_k = 8;
    int drv_skip = -1;
    bit drv_extra = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic push_ev(input int d, input int e, input int lo, input int hi, input int ones);
        ev_t ev;
        ev.done = d; ev.err = e; ev.sready = 1; ev.t_lo = lo; ev.t_hi = hi; ev.ones = ones;
        q_ev.push_back(ev);
    endtask

    task automatic issue_start(input int k);
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = K_W'(k);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((q_ev.size() != 0 || bus.busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) begin
            checks++;
            failures++;
            $display("FAIL wait_timeout pending=%0d busy=%0d", q_ev.size(), bus.busy);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, bus.start_ready, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_a_en"}, bus.a_rd_en, 0);
        check({tag, "_b_en"}, bus.b_rd_en, 0);
        check({tag, "_a_addr"}, bus.a_rd_addr, 0);
        check({tag, "_b_addr"}, bus.b_rd_addr, 0);
        check({tag, "_init"}, bus.init, 0);
    endtask

    // Array model: one early first-wave pulse per row, then N2 unload pulses after the flush.
    initial begin
        int t;
        bit pb;
        t = 0;
        pb = 1'b0;
        bus.valid_D = '0;
        forever begin
            @(negedge clk);
            if (bus.busy && !pb) t = 0; else t++;
            pb = bus.busy;
            for (int i = 0; i < N1; i++)
                bus.valid_D[i] = bus.busy && (i != drv_skip) &&
                    ((t == i + 1) || (t >= drv_k + i + 1 && t <= drv_k + i + 4) ||
                     (drv_extra && t == drv_k + i + 5));
        end
    end

    initial begin
        int t;
        int ones;
        bit pb;
        logic [4:0] cur;
        logic [4:0] prv;
        edge_t e;
        ev_t ev;
        t = 0; ones = 0; pb = 1'b0; prv = '0;
        forever begin
            @(negedge clk);
            if (bus.busy && !pb) begin t = 0; ones = 0; jobs++; end
            else t++;
            pb = bus.busy;
            cur = {bus.init[31], bus.init[0], bus.b_rd_en[3], bus.a_rd_en[7], bus.a_rd_en[0]};
            if (chk_waves) begin
                ones += $countones(bus.init);
                for (int s = 0; s < 5; s++) begin
                    if (cur[s] != prv[s]) begin
                        if (q_edge.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL edge_unexpected sig=%0d t=%0d val=%0d", s, t, cur[s]);
                        end else begin
                            e = q_edge.pop_front();
                            check("edge_sig", s, e.sig);
                            check("edge_t", t, e.t);
                            check("edge_val", cur[s], e.v);
                        end
                    end
                end
                if (bus.a_rd_en[7]) begin
                    if (q_addr7.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL a7_addr_unexpected t=%0d", t);
                    end else begin
                        check("a7_addr", bus.a_rd_addr[7*AW +: AW], q_addr7.pop_front());
                    end
                end
            end
            prv = cur;
            if (bus.done || bus.err) begin
                if (q_ev.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL ev_unexpected done=%0d err=%0d t=%0d", bus.done, bus.err, t);
                end else begin
                    ev = q_ev.pop_front();
                    check("ev_done", bus.done, ev.done);
                    check("ev_err", bus.err, ev.err);
                    check("ev_busy", bus.busy, 0);
                    check("ev_ready", bus.start_ready, ev.sready);
                    if (ev.t_lo >= 0) begin
                        checks++;
                        if (t < ev.t_lo || t > ev.t_hi) begin
                            failures++;
                            $display("FAIL ev_time got=%0d exp=%0d..%0d", t, ev.t_lo, ev.t_hi);
                        end
                    end
                    if (ev.ones >= 0) check("init_ones", ones, ev.ones);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int et[14][3];
        int jobs0;
        int n;
        et = '{'{0, 0, 1}, '{3, 1, 1}, '{3, 2, 0}, '{2, 3, 1}, '{1, 7, 1}, '{0, 8, 0}, '{3, 9, 1},
               '{3, 10, 0}, '{2, 11, 0}, '{4, 11, 1}, '{4, 12, 0}, '{1, 15, 0}, '{4, 19, 1}, '{4, 20, 0}};
        bus.start = 1'b0;
        bus.k_len = '0;

        repeat (2) @(posedge clk);
        #1 check_reset_state("rst");
        @(negedge clk) rst = 1'b0;

        push_ev(0, 1, -1, -1, -1); issue_start(5);    wait_idle(20);
        push_ev(0, 1, -1, -1, -1); issue_start(0);    wait_idle(20);
        push_ev(0, 1, -1, -1, -1); issue_start(1025); wait_idle(20);
        repeat (3) @(negedge clk);
        check("bad_k_busy", bus.busy, 0);

        for (int i = 0; i < 14; i++) begin
            edge_t e;
            e.sig = et[i][0]; e.t = et[i][1]; e.v = et[i][2];
            q_edge.push_back(e);
        end
        for (int a = 0; a < 8; a++) q_addr7.push_back(a);
        push_ev(1, 0, 20, 23, 64);
        drv_k = 8; drv_skip = -1; drv_extra = 1'b0;
        chk_waves = 1'b1;
        issue_start(8);
        wait_idle(200);
        chk_waves = 1'b0;

        drv_k = 6; drv_extra = 1'b1;
        push_ev(1, 0, 18, 21, -1);
        issue_start(6);
        wait_idle(200);
        drv_extra = 1'b0;

        drv_k = 8;
        issue_start(8);
        repeat (4) @(negedge clk);
        check("midjob_busy", bus.busy, 1);
        rst = 1'b1;
        #1 check_reset_state("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        drv_k = 1024;
        push_ev(1, 0, 1036, 1039, -1);
        jobs0 = jobs;
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = K_W'(1024);
        n = 0;
        while (!bus.busy && n < 10) begin @(negedge clk); n++; end
        while (bus.busy && n < 3000) begin @(negedge clk); n++; end
        bus.start = 1'b0;
        if (n >= 3000) begin
            checks++; failures++;
            $display("FAIL held_start_timeout cycles=%0d", n);
        end
        repeat (30) @(negedge clk);
        check("held_start_jobs", jobs - jobs0, 1);
        wait_idle(20);

        drv_k = 8; drv_skip = 5;
        push_ev(1, 1, 275, 277, -1);
        issue_start(8);
        wait_idle(600);
        check("timeout_ready", bus.start_ready, 1);
        drv_skip = -1;

        repeat (10) @(negedge clk);
        check("edge_left", q_edge.size(), 0);
        check("addr_left", q_addr7.size(), 0);
        check("ev_left", q_ev.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
